// File: rtl/tri_raster_scan.sv
// Triangle setup (edge planes + bounding box) and raster-order pixel scan feeding the ppu inside test.
// Optional: define BBOX_CLIP_EN to clip the bounding box to the screen in one extra setup cycle.
module tri_raster_scan #(
  parameter int unsigned COORD_WIDTH = 16,
  parameter int unsigned COLOR_WIDTH = 16,
  parameter int unsigned SCREEN_W    = 640,
  parameter int unsigned SCREEN_H    = 480
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          tri_valid,
  output logic                          tri_ready,
  input  logic signed [COORD_WIDTH-1:0] vx [3],
  input  logic signed [COORD_WIDTH-1:0] vy [3],
  input  logic [COLOR_WIDTH-1:0]        tri_color,
  output logic signed [COORD_WIDTH-1:0] px_x,
  output logic signed [COORD_WIDTH-1:0] px_y,
  output logic signed [COORD_WIDTH-1:0] bound_coefs [3][2],
  output logic signed [2*COORD_WIDTH-1:0] bound_const [3],
  output logic [COLOR_WIDTH-1:0]        color_out,
  output logic                          px_valid,
  input  logic                          px_ready,
  output logic                          busy,
  output logic                          done
);

  localparam int unsigned CW  = COORD_WIDTH;
  localparam int unsigned CW2 = 2 * COORD_WIDTH;

  typedef enum logic [1:0] {IDLE, SETUP, CLIP, SCAN} state_t;

  state_t               state;
  logic [1:0]           k;
  logic signed [CW-1:0] lx [3];
  logic signed [CW-1:0] ly [3];
  logic signed [CW-1:0] xmin, xmax, ymin, ymax;

  logic [1:0]            kn;
  logic signed [CW-1:0]  xa, ya, xb, yb;
  logic signed [CW-1:0]  edge_a, edge_b;
  logic signed [CW2-1:0] edge_c;
  logic signed [CW-1:0]  nxmin, nxmax, nymin, nymax;

  // Edge k runs from vertex k to vertex (k+1)%3; bbox folds in vertex k.
  always_comb begin
    kn     = (k == 2'd2) ? 2'd0 : k + 2'd1;
    xa     = lx[k];
    ya     = ly[k];
    xb     = lx[kn];
    yb     = ly[kn];
    edge_a = ya - yb;
    edge_b = xb - xa;
    edge_c = CW2'(xa) * CW2'(yb) - CW2'(xb) * CW2'(ya);
    nxmin  = (k == 2'd0 || xa < xmin) ? xa : xmin;
    nxmax  = (k == 2'd0 || xa > xmax) ? xa : xmax;
    nymin  = (k == 2'd0 || ya < ymin) ? ya : ymin;
    nymax  = (k == 2'd0 || ya > ymax) ? ya : ymax;
  end

`ifdef BBOX_CLIP_EN
  localparam logic signed [CW-1:0] X_HI = CW'(SCREEN_W - 1);
  localparam logic signed [CW-1:0] Y_HI = CW'(SCREEN_H - 1);

  logic signed [CW-1:0] cxmin, cxmax, cymin, cymax;
  logic                 clip_empty;

  always_comb begin
    cxmin      = (xmin < 0) ? '0 : xmin;
    cxmax      = (xmax > X_HI) ? X_HI : xmax;
    cymin      = (ymin < 0) ? '0 : ymin;
    cymax      = (ymax > Y_HI) ? Y_HI : ymax;
    clip_empty = (cxmin > cxmax) || (cymin > cymax);
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      k         <= 2'd0;
      tri_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      px_valid  <= 1'b0;
      px_x      <= '0;
      px_y      <= '0;
      color_out <= '0;
      xmin      <= '0;
      xmax      <= '0;
      ymin      <= '0;
      ymax      <= '0;
      for (int i = 0; i < 3; i++) begin
        lx[i]             <= '0;
        ly[i]             <= '0;
        bound_coefs[i][0] <= '0;
        bound_coefs[i][1] <= '0;
        bound_const[i]    <= '0;
      end
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (tri_valid && tri_ready) begin
            lx        <= vx;
            ly        <= vy;
            color_out <= tri_color;
            k         <= 2'd0;
            tri_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= SETUP;
          end
        end
        SETUP: begin
          bound_coefs[k][0] <= edge_a;
          bound_coefs[k][1] <= edge_b;
          bound_const[k]    <= edge_c;
          xmin <= nxmin;
          xmax <= nxmax;
          ymin <= nymin;
          ymax <= nymax;
          k    <= kn;
          if (k == 2'd2) begin
`ifdef BBOX_CLIP_EN
            state <= CLIP;
`else
            state    <= SCAN;
            px_valid <= 1'b1;
            px_x     <= nxmin;
            px_y     <= nymin;
`endif
          end
        end
`ifdef BBOX_CLIP_EN
        CLIP: begin
          xmin <= cxmin;
          xmax <= cxmax;
          ymin <= cymin;
          ymax <= cymax;
          if (clip_empty) begin
            done      <= 1'b1;
            tri_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end else begin
            px_valid <= 1'b1;
            px_x     <= cxmin;
            px_y     <= cymin;
            state    <= SCAN;
          end
        end
`endif
        SCAN: begin
          // Advance only on an accepted pixel; otherwise everything holds.
          if (px_ready) begin
            if (px_x == xmax) begin
              if (px_y == ymax) begin
                px_valid  <= 1'b0;
                done      <= 1'b1;
                tri_ready <= 1'b1;
                busy      <= 1'b0;
                state     <= IDLE;
              end else begin
                px_x <= xmin;
                px_y <= px_y + CW'(1);
              end
            end else begin
              px_x <= px_x + CW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
